// File: rtl/rf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : rf_pkg                                                     |
// | Shared register-file widths and writeback requester identifiers.     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package rf_pkg;

  // Architectural register data width.
  localparam int RF_XLEN = 32;
  // Architectural register count.
  localparam int RF_NREG = 32;
  // Register address width (log2 of RF_NREG).
  localparam int RF_AW   = 5;

  // Writeback requester identifiers; also the encoding of the last-grant state.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

  // The other requester of the pair.
  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_ALU) ? REQ_MEM : REQ_ALU;
  endfunction

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_arb2                                                    |
// | Two-way round-robin arbiter between the ALU and MEM requesters.      |
// | The grant is combinational; the last-grant record is registered.     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module rr_arb2
  import rf_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic valid_alu_i,
  input  logic valid_mem_i,
  output logic gnt_alu_o,
  output logic gnt_mem_o
);

  // Requester granted most recently. Resetting to ALU hands the first
  // contention after reset to MEM.
  req_id_e last_q;
  req_id_e last_d;

  // Last-grant state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= REQ_ALU;
    end else begin
      last_q <= last_d;
    end
  end

  // Grant selection and last-grant update; on contention the requester
  // not granted most recently wins.
  always_comb begin
    gnt_alu_o = 1'b0;
    gnt_mem_o = 1'b0;
    last_d    = last_q;
    if (valid_alu_i && valid_mem_i) begin
      if (other_req(last_q) == REQ_MEM) begin
        gnt_mem_o = 1'b1;
        last_d    = REQ_MEM;
      end else begin
        gnt_alu_o = 1'b1;
        last_d    = REQ_ALU;
      end
    end else if (valid_alu_i) begin
      gnt_alu_o = 1'b1;
      last_d    = REQ_ALU;
    end else if (valid_mem_i) begin
      gnt_mem_o = 1'b1;
      last_d    = REQ_MEM;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rf_wb_arbiter                                              |
// | Shares the single register-file write port between ALU and load unit |
// | writebacks and keeps a per-register pending scoreboard for issue.    |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int NREG = RF_NREG
) (
  input  logic             clk,
  input  logic             reset,
  // ALU writeback requester
  input  logic             alu_valid,
  input  logic [RF_AW-1:0] alu_addr,
  input  logic [XLEN-1:0]  alu_data,
  output logic             alu_ready,
  // Load-unit writeback requester
  input  logic             mem_valid,
  input  logic [RF_AW-1:0] mem_addr,
  input  logic [XLEN-1:0]  mem_data,
  output logic             mem_ready,
  // Register-file write port
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  // Issue-stage destination claim
  input  logic             iss_valid,
  input  logic [RF_AW-1:0] iss_addr,
  output logic             iss_ready,
  // Source operand hazard checks
  input  logic [RF_AW-1:0] chk_addr_1,
  input  logic [RF_AW-1:0] chk_addr_2,
  output logic             chk_busy_1,
  output logic             chk_busy_2
);

  logic             gnt_alu;
  logic             gnt_mem;

  logic             rf_we_q,    rf_we_d;
  logic [RF_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]  pending_q,  pending_d;

  logic             wb_hs;
  logic [RF_AW-1:0] wb_addr;
  logic [XLEN-1:0]  wb_data;
  logic             iss_hs;

  rr_arb2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .valid_alu_i (alu_valid),
    .valid_mem_i (mem_valid),
    .gnt_alu_o   (gnt_alu),
    .gnt_mem_o   (gnt_mem)
  );

  // Ready is the grant itself, so it can only rise alongside its own valid.
  assign alu_ready = gnt_alu;
  assign mem_ready = gnt_mem;

  // Claims on x0 are always accepted and never recorded. A register whose
  // write lands this cycle can be reclaimed at once: the set then wins.
  assign iss_ready = (iss_addr == '0) || !pending_q[iss_addr] ||
                     (rf_we_q && (rf_waddr_q == iss_addr));
  assign iss_hs    = iss_valid && iss_ready && (iss_addr != '0);

  // Busy reads straight from the scoreboard, so it stays high through the
  // rf_we cycle and drops on the edge that commits the data.
  assign chk_busy_1 = pending_q[chk_addr_1];
  assign chk_busy_2 = pending_q[chk_addr_2];

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // Mux the granted request and form the next write-port contents.
  // Writes to x0 complete the handshake but never raise rf_we.
  always_comb begin
    wb_hs      = gnt_alu || gnt_mem;
    wb_addr    = gnt_mem ? mem_addr : alu_addr;
    wb_data    = gnt_mem ? mem_data : alu_data;
    rf_we_d    = wb_hs && (wb_addr != '0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (rf_we_d) begin
      rf_waddr_d = wb_addr;
      rf_wdata_d = wb_data;
    end
  end

  // Scoreboard update: clear the register being written, then apply a new
  // claim so a same-cycle claim of that register leaves it pending.
  always_comb begin
    pending_d = pending_q;
    if (rf_we_q) begin
      pending_d[rf_waddr_q] = 1'b0;
    end
    if (iss_hs) begin
      pending_d[iss_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Write-port and scoreboard registers; reset drops any in-flight write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pending_q  <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      pending_q  <= pending_d;
    end
  end

endmodule : rf_wb_arbiter
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_rf_wb_arbiter                                           |
// | Directed self-checking bench for rf_wb_arbiter.                      |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, iss_valid;
  logic [4:0]  alu_addr, mem_addr, iss_addr, chk_addr_1, chk_addr_2;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, iss_ready, rf_we, chk_busy_1, chk_busy_2;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_checks = 0;
  int n_errors = 0;

  rf_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .iss_valid  (iss_valid),
    .iss_addr   (iss_addr),
    .iss_ready  (iss_ready),
    .chk_addr_1 (chk_addr_1),
    .chk_addr_2 (chk_addr_2),
    .chk_busy_1 (chk_busy_1),
    .chk_busy_2 (chk_busy_2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    alu_valid  = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid  = 1'b0; mem_addr = '0; mem_data = '0;
    iss_valid  = 1'b0; iss_addr = '0;
    chk_addr_1 = 5'd5; chk_addr_2 = 5'd0;

    // Reset state
    tick(); tick();
    check_eq("rst_we",    rf_we,    32'd0);
    check_eq("rst_waddr", rf_waddr, 32'd0);
    check_eq("rst_wdata", rf_wdata, 32'd0);
    check_eq("rst_busy1", chk_busy_1, 32'd0);
    reset = 1'b0;
    tick();

    // Contention after reset: MEM first, then ALU
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h11;
    mem_valid = 1'b1; mem_addr = 5'd6; mem_data = 32'h22;
    #1;
    check_eq("c0_mem_ready", mem_ready, 32'd1);
    check_eq("c0_alu_ready", alu_ready, 32'd0);
    tick();
    check_eq("c1_we",    rf_we,    32'd1);
    check_eq("c1_waddr", rf_waddr, 32'd6);
    check_eq("c1_wdata", rf_wdata, 32'h22);
    #1;
    check_eq("c1_alu_ready", alu_ready, 32'd1);
    check_eq("c1_mem_ready", mem_ready, 32'd0);
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    check_eq("c2_we",    rf_we,    32'd1);
    check_eq("c2_waddr", rf_waddr, 32'd5);
    check_eq("c2_wdata", rf_wdata, 32'h11);
    #1;
    check_eq("idle_alu_ready", alu_ready, 32'd0);
    check_eq("idle_mem_ready", mem_ready, 32'd0);
    tick();
    check_eq("c3_we",    rf_we,    32'd0);
    check_eq("c3_waddr_hold", rf_waddr, 32'd5);
    check_eq("c3_wdata_hold", rf_wdata, 32'h11);

    // Write to x0 is accepted but discarded
    mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'hFFFF_FFFF;
    #1;
    check_eq("x0_mem_ready", mem_ready, 32'd1);
    tick();
    mem_valid = 1'b0;
    check_eq("x0_we", rf_we, 32'd0);
    tick();

    // Claim x7, recheck, then write it back
    iss_valid = 1'b1; iss_addr = 5'd7; chk_addr_1 = 5'd7;
    #1;
    check_eq("x7_claim_ready", iss_ready, 32'd1);
    check_eq("x7_busy_before", chk_busy_1, 32'd0);
    tick();
    #1;
    check_eq("x7_busy",         chk_busy_1, 32'd1);
    check_eq("x7_reclaim_ready", iss_ready, 32'd0);
    check_eq("x0_busy2",        chk_busy_2, 32'd0);
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h77;
    #1;
    check_eq("x7_alu_ready", alu_ready, 32'd1);
    tick();
    alu_valid = 1'b0;
    #1;
    check_eq("x7_we",        rf_we,      32'd1);
    check_eq("x7_waddr",     rf_waddr,   32'd7);
    check_eq("x7_busy_we",   chk_busy_1, 32'd1);
    check_eq("x7_iss_bypass", iss_ready, 32'd1);
    tick();
    check_eq("x7_busy_after", chk_busy_1, 32'd0);
    check_eq("x7_we_after",   rf_we,      32'd0);

    // x9: reclaim in the very cycle its write lands; set wins
    iss_valid = 1'b1; iss_addr = 5'd9; chk_addr_2 = 5'd9;
    tick();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h99;
    tick();
    alu_valid = 1'b0;
    iss_valid = 1'b1; iss_addr = 5'd9;
    #1;
    check_eq("x9_we",        rf_we,      32'd1);
    check_eq("x9_iss_ready", iss_ready,  32'd1);
    check_eq("x9_busy_we",   chk_busy_2, 32'd1);
    tick();
    #1;
    check_eq("x9_busy_kept",    chk_busy_2, 32'd1);
    check_eq("x9_reclaim_block", iss_ready, 32'd0);
    iss_valid = 1'b0;

    // Single requester granted on consecutive cycles (last grant is ALU)
    alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'hA0;
    #1;
    check_eq("alu_only_ready0", alu_ready, 32'd1);
    tick();
    alu_addr = 5'd11; alu_data = 32'hB0;
    #1;
    check_eq("alu_only_ready1", alu_ready, 32'd1);
    check_eq("alu_only_waddr0", rf_waddr, 32'd10);
    tick();
    alu_valid = 1'b0;
    check_eq("alu_only_waddr1", rf_waddr, 32'd11);
    check_eq("alu_only_wdata1", rf_wdata, 32'hB0);
    tick();

    // Reset the cycle after a handshake to x3
    mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'h33; chk_addr_1 = 5'd3;
    #1;
    check_eq("x3_mem_ready", mem_ready, 32'd1);
    tick();
    mem_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("x3_rst_we",    rf_we,      32'd0);
    check_eq("x3_rst_busy1", chk_busy_1, 32'd0);
    check_eq("x3_rst_busy2", chk_busy_2, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("x3_no_we_%0d", i), rf_we, 32'd0);
    end

    // Contention after the mid-run reset goes to MEM again
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h1;
    mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'h2;
    #1;
    check_eq("rst2_mem_ready", mem_ready, 32'd1);
    check_eq("rst2_alu_ready", alu_ready, 32'd0);
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    check_eq("rst2_waddr", rf_waddr, 32'd2);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_rf_wb_arbiter
`default_nettype wire

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter: XLEN, 32, register data width.
REQ-002 SHALL have parameter: NREG, 32, architectural register count (address width 5).
REQ-003 SHALL have clock clk; reset reset, asynchronous, active-high.
REQ-004 SHALL have ports:
  clk  in  1  clock
  reset  in  1  async active-high reset
  alu_valid  in  1  ALU writeback request
  alu_addr  in  5  ALU destination register
  alu_data  in  XLEN  ALU result
  alu_ready  out  1  ALU request accepted this cycle
  mem_valid  in  1  load-unit writeback request
  mem_addr  in  5  load destination register
  mem_data  in  XLEN  load result
  mem_ready  out  1  load request accepted this cycle
  rf_we  out  1  register-file write enable (registered)
  rf_waddr  out  5  register-file write address (registered)
  rf_wdata  out  XLEN  register-file write data (registered)
  iss_valid  in  1  issue stage claims destination register
  iss_addr  in  5  claimed register
  iss_ready  out  1  claim accepted this cycle
  chk_addr_1  in  5  source operand 1 to check
  chk_addr_2  in  5  source operand 2 to check
  chk_busy_1  out  1  operand 1 has pending write
  chk_busy_2  out  1  operand 2 has pending write

Function
REQ-005 SHALL share the single RF write port between ALU and MEM requesters; handshake = valid && ready on the same cycle.
REQ-006 SHALL grant round-robin: one requester valid -> granted; both valid -> grant the one not granted most recently; neither -> no grant.
REQ-007 SHALL drive alu_ready/mem_ready combinationally from the grant; at most one ready high per cycle; ready never high without its valid.
REQ-008 SHALL register granted request: cycle after handshake rf_we=1, rf_waddr/rf_wdata = granted addr/data; otherwise rf_we=0, addr/data hold last value.
REQ-009 SHALL accept handshakes to address 0 but keep rf_we=0 for them (write discarded).
REQ-010 SHALL sustain one write per cycle; latency handshake->rf_we exactly 1 cycle.
REQ-011 SHALL hold a per-register pending bit (NREG bits); bit 0 constant 0.
REQ-012 SHALL set pending[iss_addr] on iss_valid && iss_ready with iss_addr != 0.
REQ-013 SHALL clear pending[rf_waddr] at the clock edge ending a cycle with rf_we=1 (the edge the RF captures the data).
REQ-014 SHALL drive iss_ready = (iss_addr == 0) || !pending[iss_addr] || (rf_we && rf_waddr == iss_addr).
REQ-015 SHALL, on simultaneous set and clear of the same register, leave pending = 1 (set wins).
REQ-016 SHALL drive chk_busy_n = pending[chk_addr_n] combinationally; address 0 always 0; busy stays 1 through the rf_we cycle.
REQ-017 SHALL not check writeback addresses against pending; unclaimed writebacks are written normally.

Reset
REQ-018 SHALL on reset: pending all 0, rf_we=0, rf_waddr=0, rf_wdata=0, last-grant = ALU (first contention goes to MEM).
REQ-019 SHALL drop any in-flight write when reset asserts mid-operation; no rf_we pulse after reset release until a new handshake.

Structure
REQ-020 SHALL take XLEN, NREG, register address width and requester-id enum (REQ_ALU, REQ_MEM) from shared package rf_pkg.
REQ-021 SHALL implement arbitration in one sub-module rr_arb2 (2-way round-robin, last-grant state inside); scoreboard and output register in top level.

Verification
REQ-022 Both valid after reset, alu x5=0x11, mem x6=0x22 held -> cycle0 mem_ready=1; next cycle rf_we=1,x6=0x22 and alu_ready=1; then rf_we x5=0x11.
REQ-023 mem_valid to x0 data 0xFFFF_FFFF -> mem_ready=1, next cycle rf_we=0.
REQ-024 iss claim x7; next cycle chk_addr_1=7 -> busy=1, second claim x7 iss_ready=0; alu writes x7 -> busy=1 during rf_we cycle, 0 after.
REQ-025 x9 pending, rf_we cycle for x9 with iss_valid x9 same cycle -> iss_ready=1, pending[9] remains 1 afterward.
REQ-026 Reset asserted the cycle after handshake to x3 -> rf_we=0 immediately, all chk_busy=0, no x3 write after release.
